// File: rtl/alu_pkg.sv
// Shared ALU op-code definitions for the decoder and the ALU logic unit.
// No logic; constants and types only.
// Backpressure: not applicable.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_NOR     = 3'b011,
        OP_ANDN    = 3'b100,
        OP_ORN     = 3'b101,
        OP_XNOR    = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise logic core: eight ops on WIDTH-bit operands, plus zero and illegal-op flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipe owns all flow control.
module alu_logic_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             err
);

    // Op decode; inversions naturally stay within WIDTH bits.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_XNOR: y = ~(a ^ b);
            default: begin
                // Only OP_ILLEGAL lands here: force a clean zero result and flag it.
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

    assign zero = ~|y;

endmodule

// File: rtl/alu_logic_pipe.sv
// Pipelined bitwise logic unit with pass-through tag; compute at entry, STAGES register stages.
// Latency: exactly STAGES cycles from acceptance to out_valid when not stalled; 1 result/cycle.
// Backpressure: per-stage valid/ready, bubbles collapse; in_ready is combinational from out_ready.
module alu_logic_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAGW-1:0]  out_tag
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             err;
        logic [TAGW-1:0]  tag;
    } stage_t;

    logic [WIDTH-1:0]  core_y;
    logic              core_zero;
    logic              core_err;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    stage_t            dat_q  [STAGES];
    stage_t            dat_d  [STAGES];

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] up_vld;
    stage_t            up_dat [STAGES];

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (in_a),
        .b    (in_b),
        .op   (in_op),
        .y    (core_y),
        .zero (core_zero),
        .err  (core_err)
    );

    // Ready ripples back from the consumer: a stage can take data if empty or draining this cycle.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0] && !rst;

    // Upstream view of each stage: stage 0 sees the core result, later stages see their predecessor.
    always_comb begin
        up_vld[0]    = in_valid;
        up_dat[0]    = '{y: core_y, zero: core_zero, err: core_err, tag: in_tag};
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld_q[k-1];
            up_dat[k] = dat_q[k-1];
        end
    end

    // Stage next-state: load when ready; data only overwritten by a real transaction.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = vld_q[k];
            dat_d[k] = dat_q[k];
            if (rdy[k]) begin
                vld_d[k] = up_vld[k];
                if (up_vld[k]) begin
                    dat_d[k] = up_dat[k];
                end
            end
        end
    end

    // Stage registers; reset discards anything in flight and zeroes the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_y     = dat_q[STAGES-1].y;
    assign out_zero  = dat_q[STAGES-1].zero;
    assign out_err   = dat_q[STAGES-1].err;
    assign out_tag   = dat_q[STAGES-1].tag;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed bench for alu_logic_pipe: default config plus WIDTH=8/STAGES=1 and WIDTH=1/STAGES=4.
// Latency: checked against STAGES on every unstalled result.
// Backpressure: exercised by scheduled out_ready stalls on the default instance.
module tb_alu_logic_pipe;

    typedef struct {
        logic [63:0] y;
        logic        z;
        logic        e;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance (WIDTH=64, STAGES=2)
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
    logic [2:0]  in_op;
    logic [63:0] in_a, in_b, out_y;
    logic [4:0]  in_tag, out_tag;

    // WIDTH=8, STAGES=1
    logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_zero, s8_out_err;
    logic [2:0]  s8_in_op;
    logic [7:0]  s8_in_a, s8_in_b, s8_out_y;
    logic [4:0]  s8_out_tag;

    // WIDTH=1, STAGES=4
    logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_out_zero, s1_out_err;
    logic [2:0]  s1_in_op;
    logic [0:0]  s1_in_a, s1_in_b, s1_out_y;
    logic [4:0]  s1_out_tag;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          stall_cnt = 0;
    int          pop_cnt   = 0;
    bit          chk_lat   = 1'b1;
    bit          accepted, last_in_ready, last_out_valid, last_out_ready;
    exp_t        pend;
    exp_t        exp_q [$];

    // Hand-computed results for a=0123456789ABCDEF, b=FEDCBA9876543210 (b == ~a)
    logic [63:0] ao_y [8] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                              64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
    logic [7:0]  ao_z = 8'b1100_1001;
    // Hand-computed results for a=F0F0..., b=FF00..., ops 0..5
    logic [63:0] bp_y [6] = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0,
                              64'h0FF0_0FF0_0FF0_0FF0, 64'h000F_000F_000F_000F,
                              64'h00F0_00F0_00F0_00F0, 64'hF0FF_F0FF_F0FF_F0FF};

    logic [7:0]  e8y [20];
    logic        e8z [20], e8e [20];
    logic [0:0]  e1y [20];
    logic        e1z [20], e1e [20];

    always #5 clk = ~clk;

    alu_logic_pipe #(.WIDTH(64), .STAGES(2), .TAGW(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_err(out_err), .out_tag(out_tag)
    );

    alu_logic_pipe #(.WIDTH(8), .STAGES(1), .TAGW(5)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_op(s8_in_op),
        .in_a(s8_in_a), .in_b(s8_in_b), .in_tag(5'd0), .out_valid(s8_out_valid), .out_ready(1'b1),
        .out_y(s8_out_y), .out_zero(s8_out_zero), .out_err(s8_out_err), .out_tag(s8_out_tag)
    );

    alu_logic_pipe #(.WIDTH(1), .STAGES(4), .TAGW(5)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_op(s1_in_op),
        .in_a(s1_in_a), .in_b(s1_in_b), .in_tag(5'd0), .out_valid(s1_out_valid), .out_ready(1'b1),
        .out_y(s1_out_y), .out_zero(s1_out_zero), .out_err(s1_out_err), .out_tag(s1_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [63:0] ref_y(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return ~(a ^ b);
            default: return 64'h0;
        endcase
    endfunction

    // One cycle of the default instance: entered and left at posedge+1, samples at posedge+2.
    task automatic tick();
        exp_t e;
        out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_out_ready = out_ready;
        accepted       = in_valid && in_ready;
        if (accepted) begin
            e     = pend;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        if (out_valid && !out_ready && exp_q.size() > 0) begin
            check("stall_y", out_y, exp_q[0].y);
            check("stall_tag", 64'(out_tag), 64'(exp_q[0].tag));
        end
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_y", out_y, e.y);
                check("out_zero", 64'(out_zero), 64'(e.z));
                check("out_err", 64'(out_err), 64'(e.e));
                check("out_tag", 64'(out_tag), 64'(e.tag));
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] tag, input logic [63:0] ey, input logic ez, input logic ee);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        pend.y   = ey;
        pend.z   = ez;
        pend.e   = ee;
        pend.tag = tag;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (accepted) break;
        end
        check("accepted", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb, r;
        logic [2:0]  rop;
        int          p0;

        rst = 1'b1;
        in_valid = 1'b1; in_op = 3'd1; in_a = 64'h1234; in_b = 64'h5678; in_tag = 5'd3;
        out_ready = 1'b1;
        s8_in_valid = 1'b0; s8_in_op = 3'd0; s8_in_a = 8'h0; s8_in_b = 8'h0;
        s1_in_valid = 1'b0; s1_in_op = 3'd0; s1_in_a = 1'b0; s1_in_b = 1'b0;

        // Reset held 3 cycles with in_valid asserted
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", out_y, 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_no_out", 64'(pop_cnt), 64'd0);

        // All ops back-to-back, tags 0..7
        for (int i = 0; i < 8; i++) begin
            present(3'(i), 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5'(i), ao_y[i], ao_z[i], (i == 7));
        end
        drain();
        check("allops_count", 64'(pop_cnt), 64'd8);

        // Backpressure: 5 stalled cycles, 6 ops
        chk_lat = 1'b0;
        stall_cnt = 5;
        p0 = pop_cnt;
        present(3'd0, {4{16'hF0F0}}, {4{16'hFF00}}, 5'd10, bp_y[0], 1'b0, 1'b0);
        present(3'd1, {4{16'hF0F0}}, {4{16'hFF00}}, 5'd11, bp_y[1], 1'b0, 1'b0);
        in_valid = 1'b1; in_op = 3'd2; in_tag = 5'd12;
        pend.y = bp_y[2]; pend.z = 1'b0; pend.e = 1'b0; pend.tag = 5'd12;
        tick();
        check("bp_full_in_ready", 64'(last_in_ready), 64'd0);
        present(3'd2, {4{16'hF0F0}}, {4{16'hFF00}}, 5'd12, bp_y[2], 1'b0, 1'b0);
        for (int i = 3; i < 6; i++) begin
            present(3'(i), {4{16'hF0F0}}, {4{16'hFF00}}, 5'(10 + i), bp_y[i], 1'b0, 1'b0);
        end
        drain();
        check("bp_count", 64'(pop_cnt - p0), 64'd6);

        // Full pipe with simultaneous pop and push
        stall_cnt = 3;
        present(3'd0, {16{4'hA}}, {16{4'h5}}, 5'd20, 64'h0, 1'b1, 1'b0);
        present(3'd1, {16{4'hA}}, {16{4'h5}}, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        present(3'd2, {16{4'hA}}, {16{4'h5}}, 5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        check("simul_pop", 64'(last_out_valid && last_out_ready), 64'd1);
        check("simul_push", 64'(last_in_ready), 64'd1);
        drain();
        chk_lat = 1'b1;

        // Reset with two results stalled in flight
        stall_cnt = 100;
        present(3'd1, 64'h1, 64'h2, 5'd30, 64'h3, 1'b0, 1'b0);
        present(3'd1, 64'h4, 64'h8, 5'd31, 64'hC, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_cnt = 0;
        exp_q.delete();
        p0 = pop_cnt;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_stale", 64'(pop_cnt - p0), 64'd0);

        // Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=1/STAGES=4, out_ready held high
        for (int c = 0; c < 20; c++) begin
            s8_in_valid = 1'b1;
            s1_in_valid = 1'b1;
            if (c == 0) begin
                s8_in_op = 3'd5; s8_in_a = 8'h0F; s8_in_b = 8'hF0;
            end else begin
                s8_in_op = 3'($urandom_range(0, 7));
                s8_in_a  = 8'($urandom);
                s8_in_b  = 8'($urandom);
            end
            ra = 64'(s8_in_a); rb = 64'(s8_in_b);
            r  = ref_y(s8_in_op, ra, rb);
            e8y[c] = r[7:0]; e8z[c] = (r[7:0] == 8'h0); e8e[c] = (s8_in_op == 3'd7);

            rop = 3'($urandom_range(0, 7));
            s1_in_op = rop; s1_in_a = 1'($urandom); s1_in_b = 1'($urandom);
            ra = 64'(s1_in_a); rb = 64'(s1_in_b);
            r  = ref_y(rop, ra, rb);
            e1y[c] = r[0:0]; e1z[c] = (r[0] == 1'b0); e1e[c] = (rop == 3'd7);
            #1;
            check("s8_in_ready", 64'(s8_in_ready), 64'd1);
            check("s1_in_ready", 64'(s1_in_ready), 64'd1);
            if (c >= 1) begin
                check("s8_out_valid", 64'(s8_out_valid), 64'd1);
                check("s8_out_y", 64'(s8_out_y), 64'(e8y[c-1]));
                check("s8_out_zero", 64'(s8_out_zero), 64'(e8z[c-1]));
                check("s8_out_err", 64'(s8_out_err), 64'(e8e[c-1]));
            end else begin
                check("s8_lat_empty", 64'(s8_out_valid), 64'd0);
            end
            if (c == 1) check("s8_orn", 64'(s8_out_y), 64'h0F);
            if (c >= 4) begin
                check("s1_out_valid", 64'(s1_out_valid), 64'd1);
                check("s1_out_y", 64'(s1_out_y), 64'(e1y[c-4]));
                check("s1_out_zero", 64'(s1_out_zero), 64'(e1z[c-4]));
                check("s1_out_err", 64'(s1_out_err), 64'(e1e[c-4]));
            end else begin
                check("s1_lat_empty", 64'(s1_out_valid), 64'd0);
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        s8_in_valid = 1'b0;
        s1_in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_logic_pipe.md
Name: alu_logic_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the RISC-V ALU. It generalises the fixed 64-bit two-input OR to WIDTH bits and eight logic ops. It has a configurable number of register stages and a valid/ready handshake with full backpressure. It sits between the decode/issue stage and ALU result writeback, and carries an opaque tag so results can be matched to their instructions.

Parameters:
WIDTH, 64, operand/result width in bits (>=1)
STAGES, 2, number of register stages between input and output (>=1)
TAGW, 5, width of the pass-through tag (e.g. destination register index)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction present
in_ready  out  1  unit can accept input this cycle
in_op  in  3  operation select (encodings below)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_tag  in  TAGW  tag carried alongside the result
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
out_y  out  WIDTH  result
out_zero  out  1  out_y == 0
out_err  out  1  illegal op code was issued
out_tag  out  TAGW  tag of this result

Behaviour:
- Op encoding: 000 AND a&b; 001 OR a|b; 010 XOR a^b; 011 NOR ~(a|b); 100 ANDN a&~b; 101 ORN a|~b; 110 XNOR ~(a^b); 111 illegal, giving y=0 and err=1.
- All other ops give err=0.
- Compute is combinational at pipeline entry. The result, zero flag, err and tag are captured into stage 0. Stages 1..STAGES-1 only carry data. Outputs are driven from stage STAGES-1 registers (no combinational in->out path).
- Handshake: a transfer occurs on a clk edge when valid && ready.
  - Stage k accepts when it is empty or stage k+1 (the consumer, for the last stage) accepts this cycle: ready_k = !v_k || ready_{k+1}.
  - in_ready = ready_0 && !rst.
  - in_ready may depend combinationally on out_ready.
- Latency: exactly STAGES cycles from input acceptance to out_valid when not stalled. Throughput is 1 result/cycle with out_ready held high.
- Bubbles collapse: an empty stage accepts upstream data even while a downstream stage is stalled.
- Stall: while out_valid && !out_ready, out_y, out_zero, out_err and out_tag hold stable. No result is dropped or duplicated.
- Full: all STAGES stages valid and out_ready=0 -> in_ready=0. Input presented then is not consumed and must be held by the producer.
- Simultaneous events: full pipeline with out_ready=1 -> in_ready=1. The output pops and the input enters in the same cycle.
- Reset, sampled on clk when rst=1:
  - all stage valid bits clear; all data registers clear to 0.
  - After reset: out_valid=0, out_y=0, out_zero=0, out_err=0, out_tag=0, in_ready=0.
  - In-flight transactions are discarded on reset mid-operation.
  - First cycle after rst deasserts: in_ready=1.
- Width rules: NOR, ORN and XNOR are inverted across the full WIDTH only. out_zero is the reduction-NOR of the WIDTH-bit result.

Decomposition:
- Shared package alu_pkg holds the 3-bit op code constants (OP_AND .. OP_ILLEGAL) and the op-field width. This package is reused by the decoder and the ALU top.
- One combinational sub-module, alu_logic_core (WIDTH param; a, b, op -> y, zero, err), is instantiated once at the pipe entry.
- The pipe wrapper contains only the stage registers and handshake logic.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_y=0, in_ready=0. Cycle after release -> in_ready=1, nothing emitted.
- All ops, WIDTH=64, STAGES=2, out_ready=1, a=0x0123456789ABCDEF, b=0xFEDCBA9876543210, ops 000..111 on back-to-back cycles:
  - 8 results arrive in order, each 2 cycles after acceptance.
  - OR=0xFFFFFFFFFFFFFFFF; AND=0; NOR=0 with zero=1; op 111 gives y=0, zero=1, err=1.
  - Tags 0..7 are preserved.
- Backpressure: stream 6 ops with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepted; out_y/out_tag stay stable while stalled.
  - After out_ready=1, all 6 results emerge in order with no loss or duplication.
- Simultaneous pop/push: full pipe, out_ready=1 and in_valid=1 in the same cycle -> one result leaves and one enters. a=0xAAAAAAAAAAAAAAAA, b=0x5555555555555555, XOR -> 0xFFFFFFFFFFFFFFFF.
- Reset mid-operation: 2 results in flight, out_ready=0, assert rst 1 cycle -> out_valid=0. No stale result appears afterwards.
- Parameter sweep: WIDTH=8 with STAGES=1 and WIDTH=1 with STAGES=4 -> latency equals STAGES; random ops match a reference model; ORN a=0x0F, b=0xF0 -> 0x0F.
